// File: rtl/alu_console.sv
// alu_console: switch-loaded ALU with registered result/flags and a scanned
// hex 7-segment display of a selectable register.
module alu_console #(
    parameter int WIDTH    = 32,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  sw,
    input  logic              btn_a,
    input  logic              btn_b,
    input  logic              btn_f,
    input  logic [1:0]        disp_sel,
    output logic [3:0]        flags,
    output logic              res_valid,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        seg
);

    localparam int SHW = $clog2(WIDTH);
    localparam int DW  = 4 * DIGITS;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // ------------------------------------------------------------------
    // Button synchronisers: bit 0 = A, bit 1 = B, bit 2 = F
    // ------------------------------------------------------------------
    logic [2:0] sync1_q, sync2_q, prev_q;
    logic [2:0] stb;

    // Two-flop synchroniser plus edge history; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {btn_f, btn_b, btn_a};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign stb = sync2_q & ~prev_q;

    // ------------------------------------------------------------------
    // ALU datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [WIDTH-1:0] a_d, b_d, res_d;
    logic [3:0]       flags_q, flags_d;
    logic             vld_q, vld_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   sum, dif;
    logic [SHW-1:0]   shamt;
    logic             cf, of;

    // Combinational ALU on the registered operands; opcode comes live from sw
    always_comb begin
        alu_res = '0;
        cf      = 1'b0;
        of      = 1'b0;
        sum     = {1'b0, a_q} + {1'b0, b_q};
        dif     = {1'b0, a_q} - {1'b0, b_q};
        shamt   = b_q[SHW-1:0];
        case (sw[3:0])
            4'd0: alu_res = a_q & b_q;
            4'd1: alu_res = a_q | b_q;
            4'd2: alu_res = a_q ^ b_q;
            4'd3: alu_res = ~(a_q | b_q);
            4'd4: begin
                alu_res = sum[WIDTH-1:0];
                cf      = sum[WIDTH];
                of      = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd5: begin
                alu_res = dif[WIDTH-1:0];
                cf      = dif[WIDTH];   // borrow out, i.e. A <u B
                of      = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'd6:  alu_res[0] = $signed(a_q) < $signed(b_q);
            4'd7:  alu_res[0] = a_q < b_q;
            4'd8:  alu_res = a_q << shamt;
            4'd9:  alu_res = a_q >> shamt;
            4'd10: alu_res = $signed(a_q) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Next-state for operand/result registers; load/clear beats execute on res_valid
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flags_d = flags_q;
        vld_d   = vld_q;
        if (stb[0]) a_d = sw;
        if (stb[1]) b_d = sw;
        if (stb[2]) begin
            res_d   = alu_res;
            flags_d = {alu_res == '0, cf, of, alu_res[WIDTH-1]};
        end
        if (stb[0] || stb[1]) vld_d = 1'b0;
        else if (stb[2])      vld_d = 1'b1;
    end

    // Operand, result and flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            vld_q   <= vld_d;
        end
    end

    assign flags     = flags_q;
    assign res_valid = vld_q;

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    src;
    logic [WIDTH+DW-1:0] ext;
    logic [DW-1:0]       disp_val;
    logic [3:0]          nib;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;

    // Source mux, fit to the digit count, and hex decode of the next digit
    always_comb begin
        src = '0;
        case (disp_sel)
            2'd0: src = res_q;
            2'd1: src = a_q;
            2'd2: src = b_q;
            default: src[3:0] = flags_q;
        endcase
        ext      = {{DW{1'b0}}, src};
        disp_val = ext[DW-1:0];

        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        nib  = disp_val[{idx_d, 2'b00} +: 4];
        an_d = ~(DIGITS'(1) << idx_d);
        case (nib)
            4'h0: seg_d = 8'hC0;
            4'h1: seg_d = 8'hF9;
            4'h2: seg_d = 8'hA4;
            4'h3: seg_d = 8'hB0;
            4'h4: seg_d = 8'h99;
            4'h5: seg_d = 8'h92;
            4'h6: seg_d = 8'h82;
            4'h7: seg_d = 8'hF8;
            4'h8: seg_d = 8'h80;
            4'h9: seg_d = 8'h90;
            4'hA: seg_d = 8'h88;
            4'hB: seg_d = 8'h83;
            4'hC: seg_d = 8'hC6;
            4'hD: seg_d = 8'hA1;
            4'hE: seg_d = 8'h86;
            default: seg_d = 8'h8E;
        endcase
    end

    // Scan counter, digit index and registered an/seg, updated together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= ~DIGITS'(1);
            seg_q <= 8'hC0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_alu_console.sv
// Bench for alu_console: behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomised button/switch traffic.
module tb_alu_console;

    localparam int W  = 32;
    localparam int ND = 8;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  sw = '0;
    logic          btn_a = 1'b0, btn_b = 1'b0, btn_f = 1'b0;
    logic [1:0]    disp_sel = 2'd0;
    logic [3:0]    flags;
    logic          res_valid;
    logic [ND-1:0] an;
    logic [7:0]    seg;

    alu_console #(.WIDTH(W), .DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn_a(btn_a), .btn_b(btn_b),
        .btn_f(btn_f), .disp_sel(disp_sel), .flags(flags),
        .res_valid(res_valid), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] SEGTAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mA, mB, mR;
    logic [3:0]  mF;
    logic        mV;
    logic [7:0]  m_an, m_seg;
    logic [2:0]  ha, hb, hf;   // last three raw button samples, [0] newest
    int          n_edges;

    function automatic void alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                output logic [31:0] r, output logic [3:0] f);
        longint unsigned s;
        logic c, o;
        c = 1'b0; o = 1'b0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = ~(a | b);
            4: begin
                s = longint'(a) + longint'(b);
                r = s[31:0]; c = s[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5: begin
                r = a - b; c = (a < b);
                o = (a[31] != b[31]) && (r[31] != a[31]);
            end
            6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7: r = (a < b) ? 32'd1 : 32'd0;
            8: r = a << b[4:0];
            9: r = a >> b[4:0];
            10: r = $signed(a) >>> b[4:0];
            default: r = 32'd0;
        endcase
        f = {r == 32'd0, c, o, r[31]};
    endfunction

    always @(posedge clk) begin
        logic [31:0] val, r;
        logic [3:0]  f;
        logic        sa, sb, sf;
        int          idx;
        if (!rst_n) begin
            mA = 0; mB = 0; mR = 0; mF = 0; mV = 0;
            ha = 0; hb = 0; hf = 0;
            n_edges = 0;
            m_an = 8'hFE; m_seg = 8'hC0;
        end else begin
            case (disp_sel)
                2'd0: val = mR;
                2'd1: val = mA;
                2'd2: val = mB;
                default: val = {28'd0, mF};
            endcase
            n_edges++;
            idx   = (n_edges / SD) % ND;
            m_an  = ~(8'd1 << idx);
            m_seg = SEGTAB[4'((val >> (4 * idx)) & 32'hF)];
            // a press sampled two edges ago, released three edges ago
            sa = ha[1] & ~ha[2];
            sb = hb[1] & ~hb[2];
            sf = hf[1] & ~hf[2];
            alu(mA, mB, sw[3:0], r, f);
            if (sf) begin mR = r; mF = f; end
            if (sa) mA = sw;
            if (sb) mB = sw;
            if (sa || sb) mV = 0;
            else if (sf)  mV = 1;
            ha = {ha[1:0], btn_a};
            hb = {hb[1:0], btn_b};
            hf = {hf[1:0], btn_f};
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_flags", {28'd0, flags}, {28'd0, mF});
            chk("cyc_valid", {31'd0, res_valid}, {31'd0, mV});
            chk("cyc_an", {24'd0, an}, {24'd0, m_an});
            chk("cyc_seg", {24'd0, seg}, {24'd0, m_seg});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [2:0] m, input int hold);
        @(posedge clk); #1 {btn_f, btn_b, btn_a} = m;
        repeat (hold) @(posedge clk);
        #1 {btn_f, btn_b, btn_a} = 3'b000;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        sw = a; press(3'b001, 1);
        sw = b; press(3'b010, 1);
        sw = {28'd0, op}; press(3'b100, 1);
    endtask

    // Wait for the scan to enter digit 0; returns 0 if it never does
    task automatic align(output bit ok);
        logic [7:0] prev;
        ok = 0;
        prev = an;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            if (an == 8'hFE && prev != 8'hFE) ok = 1;
            else prev = an;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL scan_align actual_an=%h expected=fe within 60 cycles", an);
        end
    endtask

    // Recover the displayed value by watching one full scan
    task automatic read_disp(input logic [1:0] sel, output logic [31:0] v);
        bit ok;
        v = 0;
        @(posedge clk); #1 disp_sel = sel;
        repeat (2) @(negedge clk);
        align(ok);
        if (ok) begin
            for (int d = 0; d < ND; d++) begin
                for (int k = 0; k < 16; k++)
                    if (SEGTAB[k] == seg) v[4*d +: 4] = 4'(k);
                repeat (SD) @(negedge clk);
            end
        end
    endtask

    logic [31:0] rv;
    logic [7:0]  exp_seg [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    initial begin
        bit ok;
        // reset
        rst_n = 0;
        repeat (2) @(posedge clk);
        chk_en = 1;
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_flags", {28'd0, flags}, 32'h0);
        chk("rst_valid", {31'd0, res_valid}, 32'h0);
        chk("rst_an", {24'd0, an}, 32'hFE);
        chk("rst_seg", {24'd0, seg}, 32'hC0);

        // ADD overflow with strobe latency
        sw = 32'h7FFFFFFF; press(3'b001, 1);
        sw = 32'h1;        press(3'b010, 1);
        sw = 32'h4;
        @(posedge clk); #1 btn_f = 1;
        @(posedge clk); #1 btn_f = 0;
        @(posedge clk); @(negedge clk);
        chk("add_valid_k1", {31'd0, res_valid}, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("add_valid_k2", {31'd0, res_valid}, 32'h1);
        chk("add_flags", {28'd0, flags}, 32'h3);
        chk("model_add_res", mR, 32'h80000000);
        read_disp(2'd0, rv);
        chk("add_res", rv, 32'h80000000);

        // SUB zero and SUB borrow
        load(32'd5, 32'd5, 4'd5);
        chk("subz_flags", {28'd0, flags}, 32'h8);
        read_disp(2'd0, rv);
        chk("subz_res", rv, 32'h0);
        load(32'd0, 32'd1, 4'd5);
        chk("subb_flags", {28'd0, flags}, 32'h5);
        chk("model_subb_flags", {28'd0, mF}, 32'h5);
        read_disp(2'd0, rv);
        chk("subb_res", rv, 32'hFFFFFFFF);

        // SRA, SLT, SLTU
        load(32'h80000000, 32'd4, 4'd10);
        chk("sra_flags", {28'd0, flags}, 32'h1);
        read_disp(2'd0, rv);
        chk("sra_res", rv, 32'hF8000000);
        load(32'hFFFFFFFF, 32'd1, 4'd6);
        read_disp(2'd0, rv);
        chk("slt_res", rv, 32'h1);
        sw = 32'd7; press(3'b100, 1);
        read_disp(2'd0, rv);
        chk("sltu_res", rv, 32'h0);
        chk("sltu_flags", {28'd0, flags}, 32'h8);

        // Scan order for result 0x12345678
        load(32'h12345678, 32'h0, 4'd1);
        @(posedge clk); #1 disp_sel = 2'd0;
        repeat (2) @(negedge clk);
        align(ok);
        if (ok) begin
            for (int d = 0; d < ND + 1; d++) begin
                for (int c = 0; c < SD; c++) begin
                    chk("scan_an", {24'd0, an}, {24'd0, ~(8'd1 << (d % ND))});
                    chk("scan_seg", {24'd0, seg}, {24'd0, exp_seg[d % ND]});
                    @(negedge clk);
                end
            end
        end

        // Coincident A load and execute: old A used, valid cleared
        load(32'd3, 32'd5, 4'd4);
        chk("coin_pre_valid", {31'd0, res_valid}, 32'h1);
        sw = 32'h14; press(3'b101, 1);
        chk("coin_valid", {31'd0, res_valid}, 32'h0);
        read_disp(2'd0, rv);
        chk("coin_res", rv, 32'h8);
        read_disp(2'd1, rv);
        chk("coin_a", rv, 32'h14);

        // Held button loads once
        sw = 32'h111;
        @(posedge clk); #1 btn_b = 1;
        repeat (5) @(posedge clk);
        #1 sw = 32'h222;
        repeat (95) @(posedge clk);
        #1 btn_b = 0;
        repeat (4) @(posedge clk);
        read_disp(2'd2, rv);
        chk("hold_b", rv, 32'h111);

        // Reset while an execute is in the synchroniser
        load(32'h7FFFFFFF, 32'd1, 4'd4);
        @(posedge clk); #1 btn_f = 1;
        @(posedge clk); #1 btn_f = 0; rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("rstmid_flags", {28'd0, flags}, 32'h0);
        chk("rstmid_valid", {31'd0, res_valid}, 32'h0);
        chk("rstmid_an", {24'd0, an}, 32'hFE);
        chk("rstmid_seg", {24'd0, seg}, 32'hC0);
        repeat (6) @(negedge clk);
        chk("rstmid_noexec", {31'd0, res_valid}, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 7))
                    0: sw = $urandom_range(0, 15);
                    1: sw = 32'h7FFFFFFF;
                    2: sw = 32'h80000000;
                    3: sw = 32'hFFFFFFFF;
                    default: sw = $urandom;
                endcase
            end
            if ($urandom_range(0, 11) == 0) btn_a = ~btn_a;
            if ($urandom_range(0, 11) == 0) btn_b = ~btn_b;
            if ($urandom_range(0, 7) == 0)  btn_f = ~btn_f;
            if ($urandom_range(0, 19) == 0) disp_sel = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 499) != 0);
        end
        #1 rst_n = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
